// File: rtl/iir_cascade_pkg.sv
// iir_cascade_pkg: shared constants, FSM state type and saturation helper for the biquad cascade
package iir_cascade_pkg;

    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;
    localparam int COEFFS_PER_STAGE = 5;
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    ovf;
        logic                    unf;
    } sat_res_t;

    function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] v, input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r.ovf = v > hi;
        r.unf = v < lo;
        r.val = r.ovf ? hi : r.unf ? lo : v;
        return r;
    endfunction

endpackage

// File: rtl/iir_biquad_dp.sv
// iir_biquad_dp: combinational Direct Form I biquad with floor-shift and saturation
module iir_biquad_dp
    import iir_cascade_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18
) (
    input  logic signed [DATA_WIDTH-1:0]  x,
    input  logic signed [DATA_WIDTH-1:0]  x1,
    input  logic signed [DATA_WIDTH-1:0]  x2,
    input  logic signed [DATA_WIDTH-1:0]  y1,
    input  logic signed [DATA_WIDTH-1:0]  y2,
    input  logic signed [COEFF_WIDTH-1:0] b0,
    input  logic signed [COEFF_WIDTH-1:0] b1,
    input  logic signed [COEFF_WIDTH-1:0] b2,
    input  logic signed [COEFF_WIDTH-1:0] a1,
    input  logic signed [COEFF_WIDTH-1:0] a2,
    output logic signed [DATA_WIDTH-1:0]  y,
    output logic                          ovf,
    output logic                          unf
);

    localparam int AW = DATA_WIDTH + COEFF_WIDTH + 3;

    function automatic logic signed [AW-1:0] dx(input logic signed [DATA_WIDTH-1:0] v);
        return {{(AW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] cx(input logic signed [COEFF_WIDTH-1:0] v);
        return {{(AW-COEFF_WIDTH){v[COEFF_WIDTH-1]}}, v};
    endfunction

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shr;
    sat_res_t             sr;

    // multiply-accumulate at full precision, drop fraction toward -inf, clamp to sample range
    always_comb begin
        acc = cx(b0) * dx(x) + cx(b1) * dx(x1) + cx(b2) * dx(x2) - cx(a1) * dx(y1) - cx(a2) * dx(y2);
        shr = acc >>> COEFF_FRAC;
        sr  = saturate({{(SAT_W-AW){shr[AW-1]}}, shr}, DATA_WIDTH);
        y   = sr.val[DATA_WIDTH-1:0];
        ovf = sr.ovf;
        unf = sr.unf;
    end

endmodule

// File: rtl/iir_cascade.sv
// iir_cascade: programmable biquad cascade time-multiplexing one datapath across stages
module iir_cascade
    import iir_cascade_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18,
    parameter int ADDR_WIDTH  = $clog2(5 * NUM_STAGES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic [NUM_STAGES-1:0]  bypass,
    input  logic                   coeff_wr_en,
    input  logic [ADDR_WIDTH-1:0]  coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
    input  logic [ADDR_WIDTH-1:0]  coeff_rd_addr,
    output logic [COEFF_WIDTH-1:0] coeff_rd_data,
    input  logic                   flag_clr,
    output logic [NUM_STAGES-1:0]  overflow,
    output logic [NUM_STAGES-1:0]  underflow
);

    localparam int NREG = COEFFS_PER_STAGE * NUM_STAGES;
    localparam int SW   = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(1 << COEFF_FRAC);

    if (COEFF_WIDTH - COEFF_FRAC < 2 || DATA_FRAC >= DATA_WIDTH) begin : g_bad_params
        $error("iir_cascade: unsupported fixed-point format");
    end

    state_e                         state_q, state_d;
    logic [SW-1:0]                  stage_q, stage_d;
    logic signed [DATA_WIDTH-1:0]   smp_q, smp_d;
    logic [DATA_WIDTH-1:0]          out_q;
    logic                           out_valid_q;
    logic signed [COEFF_WIDTH-1:0]  coef_q [NREG];
    logic [COEFF_WIDTH-1:0]         rd_q;
    logic signed [DATA_WIDTH-1:0]   x1_q [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0]   x2_q [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0]   y1_q [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0]   y2_q [NUM_STAGES];
    logic [NUM_STAGES-1:0]          ovf_q, unf_q, ovf_set, unf_set;
    logic [ADDR_WIDTH-1:0]          base;
    logic signed [DATA_WIDTH-1:0]   dp_y, st_y;
    logic                           dp_ovf, dp_unf, byp, run;

    iir_biquad_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .COEFF_FRAC (COEFF_FRAC)
    ) u_dp (
        .x  (smp_q),
        .x1 (x1_q[stage_q]),
        .x2 (x2_q[stage_q]),
        .y1 (y1_q[stage_q]),
        .y2 (y2_q[stage_q]),
        .b0 (coef_q[base + ADDR_WIDTH'(B0)]),
        .b1 (coef_q[base + ADDR_WIDTH'(B1)]),
        .b2 (coef_q[base + ADDR_WIDTH'(B2)]),
        .a1 (coef_q[base + ADDR_WIDTH'(A1)]),
        .a2 (coef_q[base + ADDR_WIDTH'(A2)]),
        .y  (dp_y),
        .ovf(dp_ovf),
        .unf(dp_unf)
    );

    // select the active stage's coefficients/bypass and form the per-stage flag set pulses
    always_comb begin
        base             = ADDR_WIDTH'(COEFFS_PER_STAGE * int'(stage_q));
        run              = state_q == RUN;
        byp              = bypass[stage_q];
        st_y             = byp ? smp_q : dp_y;
        ovf_set          = '0;
        unf_set          = '0;
        ovf_set[stage_q] = run & ~byp & dp_ovf;
        unf_set[stage_q] = run & ~byp & dp_unf;
    end

    // sequencer: accept in IDLE/DONE, walk the stages in RUN, present the result from DONE
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        smp_d    = smp_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    smp_d   = in_data;
                    stage_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                smp_d   = st_y;
                state_d = stage_q == SW'(NUM_STAGES - 1) ? DONE : RUN;
                stage_d = stage_q == SW'(NUM_STAGES - 1) ? stage_q : stage_q + 1'b1;
            end
            DONE: begin
                in_ready = 1'b1;
                state_d  = in_valid ? RUN : IDLE;
                if (in_valid) begin
                    smp_d   = in_data;
                    stage_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, working sample and registered output strobe/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            smp_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            smp_q       <= smp_d;
            out_valid_q <= state_q == DONE;
            if (state_q == DONE) out_q <= smp_q;
        end
    end

    // per-stage history; a bypassed stage is wiped so re-enabling it starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (run) begin
            x1_q[stage_q] <= byp ? '0 : smp_q;
            x2_q[stage_q] <= byp ? '0 : x1_q[stage_q];
            y1_q[stage_q] <= byp ? '0 : dp_y;
            y2_q[stage_q] <= byp ? '0 : y1_q[stage_q];
        end
    end

    // sticky saturation flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~{NUM_STAGES{flag_clr}}) | ovf_set;
            unf_q <= (unf_q & ~{NUM_STAGES{flag_clr}}) | unf_set;
        end
    end

    // coefficient file (reset to unity pass-through) with registered readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) coef_q[r] <= (r % COEFFS_PER_STAGE == B0) ? ONE : '0;
            rd_q <= '0;
        end else begin
            if (coeff_wr_en && coeff_wr_addr < ADDR_WIDTH'(NREG)) coef_q[coeff_wr_addr] <= coeff_wr_data;
            rd_q <= coeff_rd_addr < ADDR_WIDTH'(NREG) ? coef_q[coeff_rd_addr] : '0;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_q;
    assign coeff_rd_data = rd_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule
